// File: rtl/uart_frame_decoder.sv
// Frame decoder behind the UART receive path: sync header, length, payload, additive checksum.
// Optional inter-byte timeout enabled by defining FRAME_TIMEOUT_EN.
module uart_frame_decoder #(
    parameter logic [7:0]  HEADER0        = 8'hEB,
    parameter logic [7:0]  HEADER1        = 8'h90,
    parameter int unsigned MAX_LEN        = 64,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_data_ready,
    input  logic       rx_err,
    output logic [7:0] payload_data,
    output logic       payload_valid,
    output logic [7:0] payload_index,
    output logic [7:0] frame_len,
    output logic       frame_done,
    output logic       frame_ok,
    output logic [2:0] err_code,
    output logic [7:0] err_count
);

    typedef enum logic [2:0] {HUNT0, HUNT1, LEN, PAYLOAD, CHECK} state_t;

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t     state, state_nxt;
    logic [7:0] sum, sum_nxt, cnt, cnt_nxt;
    logic [7:0] len_nxt, pd_nxt, pi_nxt, errcnt_nxt;
    logic       pv_nxt, done_nxt, ok_nxt;
    logic [2:0] code_nxt;
    logic       len_bad, timeout_hit;

    assign len_bad = (rx_data == 8'd0) || (rx_data > MAX_LEN_B);

`ifdef FRAME_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer;

    // Expiry fires on the edge where the count would reach TIMEOUT_CYCLES; a byte wins.
    assign timeout_hit = (state != HUNT0) && !rx_data_ready &&
                         (timer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || rx_data_ready || state == HUNT0 || timeout_hit)
            timer <= '0;
        else
            timer <= timer + 1'b1;
    end
`else
    logic unused_cfg;
    assign timeout_hit = 1'b0;
    assign unused_cfg  = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= HUNT0;
            sum           <= '0;
            cnt           <= '0;
            frame_len     <= '0;
            payload_data  <= '0;
            payload_index <= '0;
            payload_valid <= 1'b0;
            frame_done    <= 1'b0;
            frame_ok      <= 1'b0;
            err_code      <= '0;
            err_count     <= '0;
        end else begin
            state         <= state_nxt;
            sum           <= sum_nxt;
            cnt           <= cnt_nxt;
            frame_len     <= len_nxt;
            payload_data  <= pd_nxt;
            payload_index <= pi_nxt;
            payload_valid <= pv_nxt;
            frame_done    <= done_nxt;
            frame_ok      <= ok_nxt;
            err_code      <= code_nxt;
            err_count     <= errcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (timeout_hit) begin
            state_nxt = HUNT0;
        end else if (rx_data_ready) begin
            case (state)
                HUNT0:   if (!rx_err && rx_data == HEADER0) state_nxt = HUNT1;
                HUNT1: begin
                    if (rx_err)                  state_nxt = HUNT0;
                    else if (rx_data == HEADER1) state_nxt = LEN;
                    else if (rx_data == HEADER0) state_nxt = HUNT1;
                    else                         state_nxt = HUNT0;
                end
                LEN:     state_nxt = (rx_err || len_bad) ? HUNT0 : PAYLOAD;
                PAYLOAD: begin
                    if (rx_err)                           state_nxt = HUNT0;
                    else if (cnt == frame_len - 8'd1)     state_nxt = CHECK;
                end
                CHECK:   state_nxt = HUNT0;
                default: state_nxt = HUNT0;
            endcase
        end
    end

    always_comb begin
        sum_nxt  = sum;
        cnt_nxt  = cnt;
        len_nxt  = frame_len;
        pd_nxt   = payload_data;
        pi_nxt   = payload_index;
        pv_nxt   = 1'b0;
        done_nxt = 1'b0;
        ok_nxt   = 1'b0;
        code_nxt = 3'd0;
        if (timeout_hit) begin
            done_nxt = 1'b1;
            code_nxt = 3'd4;
        end else if (rx_data_ready) begin
            if (rx_err && state != HUNT0) begin
                done_nxt = 1'b1;
                code_nxt = 3'd3;
            end else begin
                case (state)
                    LEN: begin
                        len_nxt = rx_data;
                        sum_nxt = rx_data;
                        cnt_nxt = '0;
                        if (len_bad) begin
                            done_nxt = 1'b1;
                            code_nxt = 3'd1;
                        end
                    end
                    PAYLOAD: begin
                        pv_nxt  = 1'b1;
                        pd_nxt  = rx_data;
                        pi_nxt  = cnt;
                        sum_nxt = sum + rx_data;
                        cnt_nxt = cnt + 8'd1;
                    end
                    CHECK: begin
                        done_nxt = 1'b1;
                        if (rx_data == sum) ok_nxt = 1'b1;
                        else                code_nxt = 3'd2;
                    end
                    default: ;
                endcase
            end
        end
        errcnt_nxt = (done_nxt && !ok_nxt && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
    end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder; checks registered outputs 1 ns after each capturing edge.
module tb_uart_frame_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_data_ready = 1'b0;
    logic       rx_err = 1'b0;
    logic [7:0] payload_data, payload_index, frame_len, err_count;
    logic       payload_valid, frame_done, frame_ok;
    logic [2:0] err_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_frame_decoder #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_ready(rx_data_ready),
        .rx_err(rx_err), .payload_data(payload_data), .payload_valid(payload_valid),
        .payload_index(payload_index), .frame_len(frame_len), .frame_done(frame_done),
        .frame_ok(frame_ok), .err_code(err_code), .err_count(err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic e);
        @(negedge clk);
        rx_data = b; rx_err = e; rx_data_ready = 1'b1;
        @(posedge clk); #1;
        rx_data_ready = 1'b0; rx_err = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic chk_pay(input string tag, input logic [7:0] d, input logic [7:0] i);
        chk({tag, "_valid"}, 32'(payload_valid), 32'd1);
        chk({tag, "_data"},  32'(payload_data),  32'(d));
        chk({tag, "_index"}, 32'(payload_index), 32'(i));
    endtask

    task automatic chk_end(input string tag, input logic ok, input logic [2:0] code, input logic [7:0] ec);
        chk({tag, "_done"},  32'(frame_done),    32'd1);
        chk({tag, "_ok"},    32'(frame_ok),      32'(ok));
        chk({tag, "_code"},  32'(err_code),      32'(code));
        chk({tag, "_count"}, 32'(err_count),     32'(ec));
        chk({tag, "_nopay"}, 32'(payload_valid), 32'd0);
    endtask

    initial begin
        int n;
        do_reset();
        chk("rst_valid", 32'(payload_valid), 32'd0);
        chk("rst_done",  32'(frame_done),    32'd0);
        chk("rst_len",   32'(frame_len),     32'd0);
        chk("rst_count", 32'(err_count),     32'd0);
        chk("rst_code",  32'(err_code),      32'd0);

        // good frame: 03+11+22+33 = 69
        send(8'hEB, 0); chk("f1_h0_done", 32'(frame_done), 32'd0);
        send(8'h90, 0);
        send(8'h03, 0); chk("f1_len", 32'(frame_len), 32'h03);
        chk("f1_len_nopay", 32'(payload_valid), 32'd0);
        send(8'h11, 0); chk_pay("f1_p0", 8'h11, 8'd0);
        send(8'h22, 0); chk_pay("f1_p1", 8'h22, 8'd1);
        send(8'h33, 0); chk_pay("f1_p2", 8'h33, 8'd2);
        send(8'h69, 0); chk_end("f1", 1'b1, 3'd0, 8'd0);

        // bad checksum
        send(8'hEB, 0); send(8'h90, 0); send(8'h03, 0);
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
        chk_pay("f2_p2", 8'h33, 8'd2);
        send(8'h6A, 0); chk_end("f2", 1'b0, 3'd2, 8'd1);

        // length errors: 0 and 65
        do_reset();
        send(8'hEB, 0); send(8'h90, 0); send(8'h00, 0); chk_end("len0", 1'b0, 3'd1, 8'd1);
        send(8'hEB, 0); send(8'h90, 0); send(8'h41, 0); chk_end("len65", 1'b0, 3'd1, 8'd2);
        chk("len65_flen", 32'(frame_len), 32'h41);

        // junk and doubled header
        send(8'h55, 0); send(8'hEB, 0); send(8'hEB, 0); send(8'h90, 0); send(8'h01, 0);
        send(8'hA5, 0); chk_pay("resync_p0", 8'hA5, 8'd0);
        chk("resync_flen", 32'(frame_len), 32'h01);
        send(8'hA6, 0); chk_end("resync", 1'b1, 3'd0, 8'd2);

        // rx_err in HUNT0 is ignored: the flagged EB must not start a frame
        send(8'hEB, 1); chk("h0err_done", 32'(frame_done), 32'd0);
        send(8'h90, 0); send(8'h01, 0);
        send(8'hA5, 0); chk("h0err_nopay", 32'(payload_valid), 32'd0);
        chk("h0err_count", 32'(err_count), 32'd2);

        // framing error mid-payload, then a clean frame (02+01+02 = 05)
        send(8'hEB, 0); send(8'h90, 0); send(8'h02, 0);
        send(8'h10, 0); chk_pay("ferr_p0", 8'h10, 8'd0);
        send(8'h20, 1); chk_end("ferr", 1'b0, 3'd3, 8'd3);
        send(8'hEB, 0); send(8'h90, 0); send(8'h02, 0);
        send(8'h01, 0); chk_pay("after_p0", 8'h01, 8'd0);
        send(8'h02, 0); chk_pay("after_p1", 8'h02, 8'd1);
        send(8'h05, 0); chk_end("after", 1'b1, 3'd0, 8'd3);

        // MAX_LEN payload of 0..63: 40 + 2016 = 2080 -> 20 mod 256
        send(8'hEB, 0); send(8'h90, 0); send(8'h40, 0);
        for (int i = 0; i < 64; i++) send(8'(i), 0);
        chk_pay("max_last", 8'h3F, 8'h3F);
        send(8'h20, 0); chk_end("max", 1'b1, 3'd0, 8'd3);

        // err_count saturation
        do_reset();
        repeat (255) begin send(8'hEB, 0); send(8'h90, 0); send(8'h00, 0); end
        chk("sat_255", 32'(err_count), 32'd255);
        send(8'hEB, 0); send(8'h90, 0); send(8'h00, 0); chk_end("sat_hold", 1'b0, 3'd1, 8'd255);

        // reset mid-payload discards silently
        send(8'hEB, 0); send(8'h90, 0); send(8'h04, 0); send(8'h01, 0);
        do_reset();
        chk("mrst_valid", 32'(payload_valid), 32'd0);
        chk("mrst_data",  32'(payload_data),  32'd0);
        chk("mrst_index", 32'(payload_index), 32'd0);
        chk("mrst_len",   32'(frame_len),     32'd0);
        chk("mrst_count", 32'(err_count),     32'd0);
        repeat (5) begin
            @(posedge clk); #1;
            chk("mrst_nodone", 32'(frame_done), 32'd0);
        end

        // inter-byte silence after EB 90 04 01
        send(8'hEB, 0); send(8'h90, 0); send(8'h04, 0); send(8'h01, 0);
`ifdef FRAME_TIMEOUT_EN
        n = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (frame_done) begin n = k; break; end
        end
        chk("tmo_cycles", 32'(n), 32'd100);
        chk_end("tmo", 1'b0, 3'd4, 8'd1);
`else
        n = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (frame_done) n++;
        end
        chk("wait_nodone", 32'(n), 32'd0);
        // 04+01+02+03+04 = 0E
        send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
        chk_pay("wait_p3", 8'h04, 8'd3);
        send(8'h0E, 0); chk_end("wait", 1'b1, 3'd0, 8'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
